// File: rtl/coin_pkg.sv
// Shared types and constants for the coin conditioner.
// Optional running tally is enabled with the COIN_TALLY_EN macro.
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKLE,
        COIN_DIME,
        COIN_QUARTER
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_EMIT
    } out_state_t;

    localparam int unsigned CENTS_NICKLE  = 5;
    localparam int unsigned CENTS_DIME    = 10;
    localparam int unsigned CENTS_QUARTER = 25;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned JAM_CYCLES_DEF      = 1024;

    function automatic logic [4:0] coin_cents(input coin_t c);
        logic [4:0] v;
        v = 5'd0;
        case (c)
            COIN_NICKLE:  v = 5'(CENTS_NICKLE);
            COIN_DIME:    v = 5'(CENTS_DIME);
            COIN_QUARTER: v = 5'(CENTS_QUARTER);
            default:      v = 5'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchronizer, debounce counter,
// jam timer and registered rising-edge event.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned JAM_CYCLES      = JAM_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic rise_o,
    output logic jam_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned JW = $clog2(JAM_CYCLES + 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic [JW-1:0] jcnt_q, jcnt_d;
    logic          jam_q, jam_d;
    logic          rise_q, rise_d;
    logic          toggle;

    always_comb begin
        toggle = 1'b0;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d  = '0;
            deb_d  = ~deb_q;
            toggle = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Jam timer only runs on cycles where the level was already high.
    always_comb begin
        jcnt_d = jcnt_q;
        jam_d  = jam_q;
        if (!deb_d) begin
            jcnt_d = '0;
            jam_d  = 1'b0;
        end else if (deb_q && !jam_q) begin
            if (jcnt_q == JW'(JAM_CYCLES - 1)) begin
                jam_d = 1'b1;
            end else begin
                jcnt_d = jcnt_q + 1'b1;
            end
        end
    end

    assign rise_d = toggle & deb_d & ~jam_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            jcnt_q <= '0;
            jam_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            jcnt_q <= jcnt_d;
            jam_q  <= jam_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;
    assign jam_o  = jam_q;

endmodule

// File: rtl/coin_conditioner.sv
// Conditions three coin sensors into clean one-cycle coin pulses.
// Define COIN_TALLY_EN to add the saturating tally_cents output.
module coin_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned JAM_CYCLES      = JAM_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw_nickle,
    input  logic        raw_dime,
    input  logic        raw_quarter,
    input  logic        busy,
    output logic        nickle,
    output logic        dime,
    output logic        quarter,
    output logic        reject,
`ifdef COIN_TALLY_EN
    output logic [15:0] tally_cents,
`endif
    output logic [2:0]  jam
);

    logic [2:0] ev;
    logic [2:0] raw;
    logic       single, multi;
    coin_t      ev_coin;

    out_state_t state_q, state_d;
    coin_t      pend_q, pend_d;
    coin_t      emit_d;
    logic       rej_d;
    logic       nick_q, dime_q, quar_q, rej_q;

    assign raw = {raw_quarter, raw_dime, raw_nickle};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .JAM_CYCLES     (JAM_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (raw[i]),
            .rise_o(ev[i]),
            .jam_o (jam[i])
        );
    end

    assign single = $onehot(ev);
    assign multi  = (ev != 3'b000) && !single;

    always_comb begin
        case (ev)
            3'b001:  ev_coin = COIN_NICKLE;
            3'b010:  ev_coin = COIN_DIME;
            3'b100:  ev_coin = COIN_QUARTER;
            default: ev_coin = COIN_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        emit_d  = COIN_NONE;
        rej_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_EMIT: begin
                state_d = ST_IDLE;
                if (multi) begin
                    rej_d = 1'b1;
                end else if (single) begin
                    pend_d = ev_coin;
                    if (busy) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_EMIT;
                        emit_d  = ev_coin;
                    end
                end
            end
            // Only one coin can wait; anything arriving now is refused.
            ST_HOLD: begin
                rej_d = |ev;
                if (!busy) begin
                    state_d = ST_EMIT;
                    emit_d  = pend_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= COIN_NONE;
            nick_q  <= 1'b0;
            dime_q  <= 1'b0;
            quar_q  <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            nick_q  <= (emit_d == COIN_NICKLE);
            dime_q  <= (emit_d == COIN_DIME);
            quar_q  <= (emit_d == COIN_QUARTER);
            rej_q   <= rej_d;
        end
    end

    assign nickle  = nick_q;
    assign dime    = dime_q;
    assign quarter = quar_q;
    assign reject  = rej_q;

`ifdef COIN_TALLY_EN
    logic [15:0] tally_q, tally_d;
    logic [16:0] sum;

    assign sum     = {1'b0, tally_q} + {12'd0, coin_cents(emit_d)};
    assign tally_d = sum[16] ? 16'hFFFF : sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally_q <= 16'd0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign tally_cents = tally_q;
`endif

endmodule

// File: tb/tb_coin_conditioner.sv
// Scoreboard bench for coin_conditioner: expected pulses are queued
// with their cycle stamp and matched by a negedge monitor.
module tb_coin_conditioner;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_nickle, raw_dime, raw_quarter, busy;
    logic       nickle, dime, quarter, reject;
    logic [2:0] jam;
`ifdef COIN_TALLY_EN
    logic [15:0] tally_cents;
`endif

    localparam logic [3:0] K_REJ = 4'b0001;
    localparam logic [3:0] K_NIC = 4'b0010;
    localparam logic [3:0] K_DIM = 4'b0100;
    localparam logic [3:0] K_QUA = 4'b1000;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    coin_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_nickle (raw_nickle),
        .raw_dime   (raw_dime),
        .raw_quarter(raw_quarter),
        .busy       (busy),
        .nickle     (nickle),
        .dime       (dime),
        .quarter    (quarter),
        .reject     (reject),
`ifdef COIN_TALLY_EN
        .tally_cents(tally_cents),
`endif
        .jam        (jam)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [3:0] k;
        exp_t       e;
        k = {quarter, dime, nickle, reject};
        if (k != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (k !== e.kind || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             k, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int t);
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= t) break;
        end
    endtask

    task automatic wait_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic push(input logic [3:0] k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int p;
        rst_n = 1'b0;
        raw_nickle = 0; raw_dime = 0; raw_quarter = 0; busy = 0;
        step(3);
        @(negedge clk);
        checks++;
        if ({quarter, dime, nickle, reject} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000",
                     {quarter, dime, nickle, reject});
        end
        checks++;
        if (jam !== 3'b000) begin
            errors++;
            $display("FAIL reset_jam: got %b, required 000", jam);
        end
        raw_dime = 1'b1;
        step(2);
        p = cyc;
        rst_n = 1'b1;
        push(K_DIM, p + LAT);
        step(12);
        raw_dime = 1'b0;
        step(10);
        check_drained("reset_release_dime");
    endtask

    task automatic test_bounce_dime();
        int p;
        raw_dime = 1; step(1);
        raw_dime = 0; step(1);
        raw_dime = 1; step(1);
        raw_dime = 0; step(1);
        raw_dime = 1;
        p = cyc;
        push(K_DIM, p + LAT);
        step(20);
        raw_dime = 0;
        step(12);
        check_drained("bounce_dime");
    endtask

    task automatic test_collision();
        int p;
        raw_nickle = 1; raw_quarter = 1;
        p = cyc;
        push(K_REJ, p + LAT);
        step(12);
        raw_nickle = 0; raw_quarter = 0;
        step(12);
        check_drained("collision");
    endtask

    task automatic test_back_to_back();
        int p;
        raw_nickle = 1;
        p = cyc;
        push(K_NIC, p + LAT);
        step(1);
        raw_dime = 1;
        push(K_DIM, p + 1 + LAT);
        step(12);
        raw_nickle = 0; raw_dime = 0;
        step(12);
        check_drained("back_to_back");
    endtask

    task automatic test_hold();
        int p;
        busy = 1;
        raw_quarter = 1;
        p = cyc;
        wait_pos(p + 8);
        raw_quarter = 0;
        wait_pos(p + 10);
        raw_nickle = 1;
        push(K_REJ, p + 17);
        wait_pos(p + 14);
        raw_nickle = 0;
        wait_pos(p + 20);
        busy = 0;
        push(K_QUA, p + 21);
        step(15);
        check_drained("hold_busy");
    endtask

    task automatic test_jam();
        int p;
        int q;
        raw_nickle = 1;
        p = cyc;
        push(K_NIC, p + LAT);
        wait_neg(p + 1029);
        checks++;
        if (jam !== 3'b000) begin
            errors++;
            $display("FAIL jam_early: got %b, required 000", jam);
        end
        wait_neg(p + 1030);
        checks++;
        if (jam !== 3'b001) begin
            errors++;
            $display("FAIL jam_set: got %b, required 001", jam);
        end
        wait_pos(p + 1100);
        raw_nickle = 0;
        q = cyc;
        wait_neg(q + 5);
        checks++;
        if (jam !== 3'b001) begin
            errors++;
            $display("FAIL jam_hold: got %b, required 001", jam);
        end
        wait_neg(q + 6);
        checks++;
        if (jam !== 3'b000) begin
            errors++;
            $display("FAIL jam_clear: got %b, required 000", jam);
        end
        step(5);
        check_drained("jam");
    endtask

    task automatic test_reset_hold();
        int p;
        busy = 1;
        raw_dime = 1;
        p = cyc;
        wait_pos(p + 8);
        raw_dime = 0;
        wait_pos(p + 10);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({quarter, dime, nickle, reject, jam} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold_outputs: got %b, required 0000000",
                     {quarter, dime, nickle, reject, jam});
        end
        step(2);
        rst_n = 1'b1;
        busy = 0;
        step(20);
        check_drained("reset_hold");
    endtask

`ifdef COIN_TALLY_EN
    task automatic coin_in(input int ch);
        int p;
        p = cyc;
        case (ch)
            0: begin raw_nickle = 1; push(K_NIC, p + LAT); end
            1: begin raw_dime = 1; push(K_DIM, p + LAT); end
            default: begin raw_quarter = 1; push(K_QUA, p + LAT); end
        endcase
        step(9);
        raw_nickle = 0; raw_dime = 0; raw_quarter = 0;
        step(8);
    endtask

    task automatic test_tally();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        coin_in(2); coin_in(2); coin_in(1); coin_in(0);
        checks++;
        if (tally_cents !== 16'd65) begin
            errors++;
            $display("FAIL tally_sum: got %0d, required 65", tally_cents);
        end
        for (int i = 0; i < 2620; i++) coin_in(2);
        checks++;
        if (tally_cents !== 16'hFFFF) begin
            errors++;
            $display("FAIL tally_sat: got %0d, required 65535", tally_cents);
        end
        check_drained("tally");
    endtask
`endif

    initial begin
        test_reset();
        test_bounce_dime();
        test_collision();
        test_back_to_back();
        test_hold();
        test_jam();
        test_reset_hold();
`ifdef COIN_TALLY_EN
        test_tally();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
